// File: rtl/uart_rx_fifo_feeder_if.sv
// FIFO push port between the UART receiver and the downstream RX FIFO.
interface uart_rx_fifo_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;

  modport master (
    output wr,
    output wdata,
    input  full
  );

  modport slave (
    input  wr,
    input  wdata,
    output full
  );
endinterface

// File: rtl/uart_rx_fifo_feeder.sv
// Oversampling UART receiver pushing completed frames into an RX FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_fifo_feeder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  uart_rx_fifo_feeder_if.master fifo,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_WIDTH + 1);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_sync_q;
  logic [DIVW-1:0]       div_q, div_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  pbad_q, pbad_d;
`endif

  logic tick;
  logic samp_mid;
  logic samp_end;

  assign tick     = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign samp_mid = tick && (cnt_q == CNT_MID);
  assign samp_end = tick && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif

    // Divider idles at 0 so each frame's tick phase starts at its edge.
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (samp_mid) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (samp_end) begin
          shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (samp_end) begin
          pbad_d  = ^{shift_q, rx_sync_q};
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is caught.
        if (samp_end) begin
          state_d = S_IDLE;
          if (!rx_sync_q) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
`ifdef UART_RX_PARITY_EN
          else if (pbad_q) begin
            perr_d = 1'b1;
          end
`endif
          else if (fifo.full) begin
            ovr_d = 1'b1;
          end else begin
            wr_d    = 1'b1;
            wdata_d = shift_q;
          end
        end
      end
      S_BREAK: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign fifo.wr    = wr_q;
  assign fifo.wdata = wdata_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx_fifo_feeder.md
# uart_rx_fifo_feeder

UART receiver that deserialises an asynchronous serial line and pushes each completed byte into the downstream RX FIFO through a single-cycle write strobe. It sits between the board-level `rx` pin and the FIFO's `wr`/`wdata`/`full` ports. It owns its own oversampling baud-tick generator, start-bit validation, and frame/overrun error reporting.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000. System clock frequency in Hz.
- `BAUD`, default 9600. Line bit rate.
- `OVERSAMPLE`, default 16. Ticks per bit; must be even and ≥ 8.
- `DATA_WIDTH`, default 8. Data bits per frame, LSB first.

Ports:
- `clk`, input, 1. System clock.
- `rst`, input, 1. Reset: asynchronous, active-high.
- `rx`, input, 1. Serial line; idle high; asynchronous to `clk`.
- `full`, input, 1. Downstream FIFO full flag.
- `wr`, output, 1. One-cycle push strobe to the FIFO.
- `wdata`, output, `DATA_WIDTH`. Received byte. Valid whenever `wr` is 1; held until the next accepted frame.
- `busy`, output, 1. High in every state except IDLE.
- `frame_err`, output, 1. One-cycle pulse: stop bit sampled low.
- `overrun`, output, 1. One-cycle pulse: good frame dropped because `full` was 1.
- `parity_err`, output, 1. Present only with `UART_RX_PARITY_EN`. One-cycle pulse on parity mismatch.

## Operation
- `rx` passes through a 2-FF synchroniser. Both FFs reset to 1. All decisions use the synchronised value.
- Tick generator: divider `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer truncation. Emits a 1-clk `tick` every `DIV` clocks. The divider restarts at 0 on IDLE→START.
- Tick counter `cnt`, width `$clog2(OVERSAMPLE)`, wraps at `OVERSAMPLE-1`. Bit counter width `$clog2(DATA_WIDTH+1)`.
- State transitions:
  - IDLE → START when the synchronised `rx` is 0. `cnt` is cleared.
  - START: at `cnt == OVERSAMPLE/2-1` (mid start bit), sample `rx`.
    - `rx` = 1: false start, go to IDLE.
    - `rx` = 0: clear `cnt`, go to DATA.
  - DATA: at each `cnt == OVERSAMPLE-1`, shift the sample into the MSB of the shift register (LSB-first reception). After `DATA_WIDTH` samples, go to PARITY if enabled, else STOP.
  - PARITY: one sample at `cnt == OVERSAMPLE-1`; go to STOP.
  - STOP: one sample at `cnt == OVERSAMPLE-1`, then decide:
    - Stop = 1, no parity error, `full` = 0: pulse `wr`, load `wdata`, go to IDLE.
    - Stop = 1, no parity error, `full` = 1: pulse `overrun`, drop byte, go to IDLE.
    - Stop = 0: pulse `frame_err`, drop byte, go to BREAK.
    - Stop = 1, parity error: pulse `parity_err`, drop byte, go to IDLE.
  - BREAK → IDLE when the synchronised `rx` is 1.
- `full` is sampled only in the stop-decision cycle. The block never writes while `full` = 1.
- Return to IDLE happens at mid stop bit, so back-to-back frames with zero idle time are received.

## Timing
- Reset values:
  - Outputs: `wr`=0, `wdata`=0, `busy`=0, `frame_err`=0, `overrun`=0, `parity_err`=0.
  - Internal: state IDLE, counters 0.
- `rst` mid-frame aborts immediately. No `wr` is issued for the partial frame.
- Synchroniser latency: 2 clk from an `rx` edge to FSM visibility.
- `wr`, `overrun`, `frame_err` and `parity_err` are registered. They assert in the clk cycle after the stop-sample tick and last exactly 1 clk. At most one of them is high per frame.
- The stop sample falls `OVERSAMPLE/2 + OVERSAMPLE*(DATA_WIDTH+1+P)` ticks after the start edge is detected, where P = 1 with parity, else 0.
- Start glitches shorter than `OVERSAMPLE/2` ticks are rejected.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in and frames carry one even-parity bit after the data.
  - The `parity_err` port exists; a mismatching frame is dropped.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state and no `parity_err` port.
  - Frame is start + `DATA_WIDTH` + stop.

## Test plan
Bench settings: `CLK_FREQ`=1_600_000, `BAUD`=10_000, `OVERSAMPLE`=16, giving `DIV`=10 and 160 clk/bit.
1. Frame 0x55, stop=1, `full`=0 → exactly one `wr` pulse, `wdata`=0x55, no error pulses, `busy` drops at mid stop bit.
2. `rx` low for 50 clk in idle → no `wr`, `busy` returns to 0 within ~85 clk, next valid 0xA3 frame received correctly.
3. Frame 0xA5 with stop bit 0, `rx` then held low 500 clk before going high → one `frame_err` pulse, no `wr`, `busy`=1 until `rx` goes high.
4. Frame 0x3C with `full`=1 → no `wr`, one `overrun` pulse, `wdata` keeps its previous value. Repeat with `full`=0 → `wr`, `wdata`=0x3C.
5. Frames 0x00 then 0xFF with zero idle gap → two `wr` pulses, 1600 clk apart, data 0x00 then 0xFF. Separate run: `rst` asserted during bit 4 of 0x81 → all outputs 0, no `wr`, next frame received correctly.
6. With `UART_RX_PARITY_EN`: frame 0x07 with parity bit 0 (wrong, even parity requires 1) → `parity_err` pulse, no `wr`. Same frame with parity bit 1 → `wr`, `wdata`=0x07.
